ks10_mem_slave: RTL



---
 rtl/ks10_mem_slave_pkg.sv | 17 +
 rtl/ks10_mem_slave_if.sv | 19 +
 rtl/ks10_mem_array.sv | 29 ++
 rtl/ks10_mem_slave.sv | 110 +++++++++++
 4 files changed

// File: rtl/ks10_mem_slave_pkg.sv
// Shared definitions for the KS10 memory responder: flag bit positions in the
// big-endian address word and the responder FSM state encodings.
package ks10_mem_slave_pkg;

    typedef logic [0:35] word_t;

    localparam int FLAG_READ  = 3;
    localparam int FLAG_WRITE = 5;
    localparam int FLAG_IO    = 10;
    localparam int ADDR_LSB   = 14;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/ks10_mem_slave_if.sv
// Arbiter-to-memory bus as seen by the KS10 memory responder.
interface ks10_mem_slave_if;
    import ks10_mem_slave_pkg::*;

    // Handshake: the master holds memREQI with stable flags/address/data until it
    // sees the one-cycle memACKO (or memNXMO), then drops memREQI for at least one
    // cycle before the next request; the slave latches everything at acceptance.
    logic  memREQI;
    word_t memADDRI;
    word_t memDATAI;
    logic  memACKO;
    word_t memDATAO;
    logic  memNXMO;

    modport master (output memREQI, memADDRI, memDATAI,
                    input  memACKO, memDATAO, memNXMO);
    modport slave  (input  memREQI, memADDRI, memDATAI,
                    output memACKO, memDATAO, memNXMO);
endinterface

// File: rtl/ks10_mem_array.sv
// Single-port synchronous 36-bit word RAM; a read and write on the same edge
// returns the old word. Only the read register is reset, never the contents.
module ks10_mem_array
    import ks10_mem_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  word_t                 wdata,
    output word_t                 rdata
);

    word_t mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (en && wr) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            rdata <= '0;
        else if (en && rd)  rdata <= mem[addr];
    end

endmodule

// File: rtl/ks10_mem_slave.sv
// KS10 main-memory bus responder: read, write and read-pause-write cycles with
// programmable wait states. Define MEM_NXM_EN to flag out-of-range addresses.
module ks10_mem_slave
    import ks10_mem_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    ks10_mem_slave_if.slave   bus,
    output logic [1:0]        debugState
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]            state;
    logic [3:0]            count;
    logic [ADDR_WIDTH-1:0] idxQ;
    word_t                 dataQ;
    logic                  rdQ;
    logic                  wrQ;
    logic                  ackQ;

    logic                  reqRd;
    logic                  reqWr;
    logic                  reqIo;
    logic [ADDR_WIDTH-1:0] reqIdx;
    logic                  accept;
    logic                  rangeErr;
    logic                  enterAck;
    logic                  unusedAddr;

    assign reqRd  = bus.memADDRI[FLAG_READ];
    assign reqWr  = bus.memADDRI[FLAG_WRITE];
    assign reqIo  = bus.memADDRI[FLAG_IO];
    assign reqIdx = bus.memADDRI[36-ADDR_WIDTH:35];
    assign accept = (state == ST_IDLE) && bus.memREQI && !reqIo && (reqRd || reqWr);
    assign unusedAddr = &{1'b0, bus.memADDRI};

`ifdef MEM_NXM_EN
    logic nxmQ;
    assign rangeErr = |bus.memADDRI[ADDR_LSB:35-ADDR_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) nxmQ <= 1'b0;
        else     nxmQ <= accept && rangeErr;
    end
    assign bus.memNXMO = nxmQ;
`else
    assign rangeErr    = 1'b0;
    assign bus.memNXMO = 1'b0;
`endif

    // With zero wait states the commit happens on the acceptance edge itself,
    // so the array is fed straight from the bus rather than the latches.
    assign enterAck = (accept && !rangeErr && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (count == 4'd0));

    ks10_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (enterAck),
        .rd    ((state == ST_IDLE) ? reqRd  : rdQ),
        .wr    ((state == ST_IDLE) ? reqWr  : wrQ),
        .addr  ((state == ST_IDLE) ? reqIdx : idxQ),
        .wdata ((state == ST_IDLE) ? bus.memDATAI : dataQ),
        .rdata (bus.memDATAO)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= 4'd0;
            idxQ  <= '0;
            dataQ <= '0;
            rdQ   <= 1'b0;
            wrQ   <= 1'b0;
            ackQ  <= 1'b0;
        end else begin
            ackQ <= enterAck;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idxQ  <= reqIdx;
                        dataQ <= bus.memDATAI;
                        rdQ   <= reqRd;
                        wrQ   <= reqWr;
                        if (rangeErr)              state <= ST_HOLD;
                        else if (WAIT_STATES == 0) state <= ST_ACK;
                        else begin
                            count <= WAIT_LOAD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (count == 4'd0) state <= ST_ACK;
                    else               count <= count - 4'd1;
                end
                ST_ACK:  state <= ST_HOLD;
                default: if (!bus.memREQI) state <= ST_IDLE;
            endcase
        end
    end

    assign bus.memACKO = ackQ;
    assign debugState  = state;

endmodule
